gate_truth_checker: RTL
=======================

Name: gate_truth_checker

Overview:
- Self-checking response end for the BASE_LOGIC gate puzzles. The existing benches only apply input vectors; this block closes the loop.
- Sweeps every input combination onto a combinational DUT, holds each one, samples the DUT output and compares it with an expected truth table.
- Reports pass/fail, the mismatch count and the first failing vector.
- Synthesizable; used in sim benches and in FPGA self-test wrappers around the puzzle modules.

Parameters:
- N_IN, 2, number of DUT inputs (1..4); table depth is 2**N_IN.
- HOLD, 2, cycles each vector is driven (>=1); the DUT output is sampled on the last hold cycle.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; honoured only in IDLE or DONE
- expected  input  2**N_IN  truth table; bit k is the expected output for stim==k, with stim bit0 = in0
- dut_out  input  1  DUT output
- stim  output  N_IN  vector driven to the DUT (bit0 to in0, bit1 to in1, ...)
- busy  output  1  high during a sweep
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  valid from done until next start; 1 when fail_count==0
- fail_count  output  N_IN+1  number of mismatching vectors
- first_fail  output  N_IN  index of the first mismatch; 0 if none

Behaviour:
- Reset, on the clk edge with rst=1: state=IDLE; stim, busy, done, pass, fail_count, first_fail all 0; hold counter 0. rst overrides everything, including mid-sweep; there is no partial result.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, latch expected into exp_q, clear fail_count/first_fail/pass, set stim=0, hold_cnt=HOLD-1, busy=1, go to RUN.
  - RUN, hold_cnt!=0: decrement hold_cnt; stim is held.
  - RUN, hold_cnt==0: sample phase. If dut_out != exp_q[stim], increment fail_count, and set first_fail=stim when fail_count was 0.
    - If stim != 2**N_IN-1: stim+1, hold_cnt=HOLD-1.
    - Else: go to DONE; done=1 for the next cycle only; busy=0; pass=(final fail_count==0).
  - DONE: stim returns to 0. A start here behaves as in IDLE; otherwise move to IDLE. pass, fail_count and first_fail are held until the next start.
- start during RUN is ignored.
- Changes to expected during RUN are ignored, because exp_q is used.
- Timing:
  - Sweep length is 2**N_IN * HOLD cycles from the start-accept edge to the last sample edge.
  - done is visible on the following cycle.
  - busy is high for exactly 2**N_IN * HOLD cycles.
- fail_count saturation is unnecessary: its maximum, 2**N_IN, fits in N_IN+1 bits.
- An X or Z on dut_out counts as a mismatch in sim (use case inequality in the compare).
- All outputs are registered.

Decomposition:
- Package gate_check_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - localparams for depth (2**N_IN) and count width;
  - puzzle truth-table constants (AND=4'b1000, OR=4'b1110, NAND=4'b0111, NOR=4'b0001, XOR=4'b0110, SECOND_TICK=4'b0010).
- No sub-module needed; a single FSM plus a hold counter.
- Benches instantiate the checker next to the puzzle module.

Test Plan:
- SECOND_TICK DUT (in0 & ~in1), expected=4'b0010, HOLD=2, start pulse -> stim runs 0,1,2,3, each held 2 cycles; done pulses 1 cycle after the 8th busy cycle; pass=1, fail_count=0, first_fail=0.
- Same DUT, expected=4'b0100 (wrong table) -> mismatches at stim 1 and 2; fail_count=2, first_fail=1, pass=0.
- dut_out tied 1, expected=4'b0010 -> fail_count=3, first_fail=0, pass=0.
- Assert rst while stim=2 -> next cycle all outputs 0 and state IDLE; a new start gives a clean full sweep with pass=1.
- start pulsed during RUN, and expected changed mid-sweep -> sweep unaffected and results match the latched table. start asserted in the DONE cycle -> a new sweep begins immediately with stim=0.
- N_IN=1, HOLD=1, NOT gate, expected=2'b01 -> 2-cycle sweep, pass=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// ============================================================================
// Module : gate_check_pkg
// Brief  : Shared types, sizing helpers and puzzle truth tables for the
//          gate truth-table checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N_IN  = 2;
    localparam int DEFAULT_DEPTH = 1 << DEFAULT_N_IN;
    localparam int DEFAULT_CNT_W = DEFAULT_N_IN + 1;

    // Truth tables for two-input puzzles: bit k is the output for stim == k.
    localparam logic [3:0] TT_AND         = 4'b1000;
    localparam logic [3:0] TT_OR          = 4'b1110;
    localparam logic [3:0] TT_NAND        = 4'b0111;
    localparam logic [3:0] TT_NOR         = 4'b0001;
    localparam logic [3:0] TT_XOR         = 4'b0110;
    localparam logic [3:0] TT_SECOND_TICK = 4'b0010;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_w_of(input int n_in);
        return n_in + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_truth_checker.sv
// ============================================================================
// Module : gate_truth_checker
// Brief  : Sweeps all input vectors onto a combinational DUT, compares its
//          output with a latched truth table and reports the result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter  int N_IN  = 2,
    parameter  int HOLD  = 2,
    localparam int DEPTH = depth_of(N_IN),
    localparam int CNT_W = cnt_w_of(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DEPTH-1:0] expected,
    input  logic             dut_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [N_IN-1:0]  first_fail
);

    localparam int               HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD - 1);
    localparam logic [N_IN-1:0]   LAST_STIM = N_IN'(DEPTH - 1);

    state_t             state_q;
    logic [DEPTH-1:0]   exp_q;
    logic [N_IN-1:0]    stim_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [CNT_W-1:0]   fail_q;
    logic [N_IN-1:0]    first_q;

    logic               accept;
    logic               mismatch;
    logic [CNT_W-1:0]   fail_d;

    assign accept   = start && (state_q == IDLE || state_q == DONE);
    // Case inequality so an X/Z from the DUT is scored as a mismatch.
    assign mismatch = (dut_out !== exp_q[stim_q]);
    assign fail_d   = fail_q + CNT_W'(mismatch);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            exp_q   <= '0;
            stim_q  <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            first_q <= '0;
        end else if (accept) begin
            state_q <= RUN;
            exp_q   <= expected;
            stim_q  <= '0;
            hold_q  <= HOLD_INIT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            first_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end else begin
                        if (mismatch) begin
                            fail_q <= fail_d;
                            if (fail_q == '0) begin
                                first_q <= stim_q;
                            end
                        end
                        if (stim_q != LAST_STIM) begin
                            stim_q <= stim_q + 1'b1;
                            hold_q <= HOLD_INIT;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (fail_d == '0);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    stim_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_q;
    assign first_fail = first_q;

endmodule

`default_nettype wire
